// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word type, fetch FSM states and constants
// reused by the fetch stage, hazard unit and IF/ID register.
package pipe_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        READY = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    // sll $0,$0,0
    localparam word_t NOP_WORD         = 32'h0000_0000;
    localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory, holds an instruction under stall and squashes stale fetches.
module fetch_stage
    import pipe_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC,
    parameter word_t NOP_INST = NOP_WORD
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        buf_q, buf_d;
    word_t        hold_addr_q, hold_addr_d;

    word_t pc_plus4;
    word_t redir_pc;
    logic  use_buf;

    assign pc_plus4 = pc_q + 32'd4;
    assign redir_pc = redirect_pc_i & ~32'h0000_0003;
    assign pc_o     = pc_plus4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            buf_q       <= '0;
            hold_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            hold_addr_q <= hold_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        hold_addr_d = hold_addr_q;
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        valid_o     = 1'b0;
        use_buf     = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                valid_o    = imem_ack_i & ~redirect_i;
                if (redirect_i) begin
                    pc_d = redir_pc;
                    // Without an ack the old request is still live and must be
                    // seen through at its original address before refetching.
                    if (!imem_ack_i) begin
                        hold_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        buf_d   = imem_data_i;
                        state_d = READY;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            READY: begin
                valid_o = ~redirect_i;
                use_buf = 1'b1;
                if (redirect_i) begin
                    pc_d    = redir_pc;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end
            end
            DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = hold_addr_q;
                if (redirect_i) begin
                    pc_d = redir_pc;
                end
                if (imem_ack_i) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Memory shares the reset, so nothing is requested or delivered meanwhile.
        if (rst_i) begin
            imem_req_o = 1'b0;
            valid_o    = 1'b0;
        end
    end

    assign inst_o = !valid_o ? NOP_INST : (use_buf ? buf_q : imem_data_i);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a hand-driven memory.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_i, stall_i, redirect_i, imem_ack_i;
    logic [31:0] redirect_pc_i, imem_data_i;
    logic        imem_req_o, valid_o;
    logic [31:0] imem_addr_o, pc_o, inst_o;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .valid_o      (valid_o),
        .pc_o         (pc_o),
        .inst_o       (inst_o)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h2400_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; outputs are
    // sampled at the following falling edge by the caller.
    task automatic drive(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] rpc, input logic ack, input logic [31:0] data);
        @(posedge clk);
        #1;
        rst_i = rst; stall_i = stall; redirect_i = redir;
        redirect_pc_i = rpc; imem_ack_i = ack; imem_data_i = data;
        @(negedge clk);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr, input logic vld,
                             input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".req"},   {31'd0, imem_req_o}, 32'd1);
        chk({tag, ".addr"},  imem_addr_o, addr);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
        if (vld) chk({tag, ".pc"}, pc_o, pc);
        chk({tag, ".inst"},  inst_o, inst);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ack_i = 1'b0; imem_data_i = '0;

        // Reset with a spurious ack present
        drive(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("rst.req",   {31'd0, imem_req_o}, 32'd0);
        chk("rst.valid", {31'd0, valid_o}, 32'd0);
        chk("rst.inst",  inst_o, 32'h0);

        // Zero-latency streaming
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 0, 0, 1, mem(32'(4 * k)));
            chk_fetch($sformatf("stream%0d", k), 32'(4 * k), 1, 32'(4 * k + 4), mem(32'(4 * k)));
        end

        // Stall on ack of 0x8 for three cycles
        drive(0, 1, 0, 0, 1, mem(32'h8));
        chk_fetch("stall.ack", 32'h8, 1, 32'hC, mem(32'h8));
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0, 0, 32'hFFFF_FFFF);
            chk($sformatf("ready%0d.req", k),   {31'd0, imem_req_o}, 32'd0);
            chk($sformatf("ready%0d.valid", k), {31'd0, valid_o}, 32'd1);
            chk($sformatf("ready%0d.pc", k),    pc_o, 32'hC);
            chk($sformatf("ready%0d.inst", k),  inst_o, mem(32'h8));
        end
        drive(0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        chk("release.valid", {31'd0, valid_o}, 32'd1);
        chk("release.inst",  inst_o, mem(32'h8));
        drive(0, 0, 0, 0, 0, 32'h1234_5678);
        chk_fetch("after_release", 32'hC, 0, 32'h10, 32'h0);

        // Redirect while held in READY
        drive(0, 1, 0, 0, 1, mem(32'hC));
        chk_fetch("ready2.ack", 32'hC, 1, 32'h10, mem(32'hC));
        drive(0, 1, 1, 32'h100, 0, 32'h0);
        chk("ready_redir.valid", {31'd0, valid_o}, 32'd0);
        chk("ready_redir.inst",  inst_o, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h100));
        chk_fetch("tgt100", 32'h100, 1, 32'h104, mem(32'h100));

        // Same-cycle redirect+ack to 0x8, then latency-3 fetch redirected to 0x40
        drive(0, 0, 1, 32'h8, 1, mem(32'h104));
        chk_fetch("redir_ack8", 32'h104, 0, 32'h108, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_fetch("lat.wait1", 32'h8, 0, 32'hC, 32'h0);
        drive(0, 0, 1, 32'h40, 0, 32'h0);
        chk_fetch("lat.redir", 32'h8, 0, 32'hC, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_fetch("drop.wait", 32'h8, 0, 32'h44, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h8));
        chk_fetch("drop.ack", 32'h8, 0, 32'h44, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h40));
        chk_fetch("tgt40", 32'h40, 1, 32'h44, mem(32'h40));

        // Redirect with ack to 0x200, then unaligned 0x203
        drive(0, 0, 1, 32'h200, 1, mem(32'h44));
        chk_fetch("redir200", 32'h44, 0, 32'h48, 32'h0);
        drive(0, 0, 1, 32'h203, 1, mem(32'h200));
        chk_fetch("redir203", 32'h200, 0, 32'h204, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h200));
        chk_fetch("tgt200", 32'h200, 1, 32'h204, mem(32'h200));

        // Newest redirect wins in DROP; PC wraps at 2^32
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        chk_fetch("wrap.redir", 32'h204, 0, 32'h208, 32'h0);
        drive(0, 0, 1, 32'h300, 0, 32'h0);
        chk_fetch("drop.redir1", 32'h204, 0, 32'h0, 32'h0);
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        chk_fetch("drop.redir2", 32'h204, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h204));
        chk_fetch("drop.ack2", 32'h204, 0, 32'h0, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'hFFFF_FFFC));
        chk_fetch("wrap", 32'hFFFF_FFFC, 1, 32'h0, mem(32'hFFFF_FFFC));

        // Reset while in DROP with a late ack
        drive(0, 0, 1, 32'h80, 1, mem(32'h0));
        chk_fetch("pre_drop", 32'h0, 0, 32'h4, 32'h0);
        drive(0, 0, 1, 32'h10, 0, 32'h0);
        chk_fetch("enter_drop", 32'h80, 0, 32'h84, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_fetch("in_drop", 32'h80, 0, 32'h14, 32'h0);
        drive(1, 0, 0, 0, 1, mem(32'h80));
        chk("rst_drop.req",   {31'd0, imem_req_o}, 32'd0);
        chk("rst_drop.valid", {31'd0, valid_o}, 32'd0);
        chk("rst_drop.inst",  inst_o, 32'h0);
        drive(0, 0, 0, 0, 0, 32'h0);
        chk_fetch("post_rst", 32'h0, 0, 32'h4, 32'h0);
        drive(0, 0, 0, 0, 1, mem(32'h0));
        chk_fetch("post_rst.ack", 32'h0, 1, 32'h4, mem(32'h0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
